fetch_unit: RTL

- Parametrised successor to the plain PC-plus-ROM fetch path. Adds a reset vector, a configurable step, branch redirect with flush, and a decoupling instruction queue with a valid/ready handshake to decode.
- Drives a synchronous instruction memory with one-cycle read latency.
- Sits between the instruction memory and decode in the next-generation (pipelined) core.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the fetch path.
package fetch_pkg;
    localparam int          ADDR_W_DEF     = 32;
    localparam int          INST_W_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam int          PC_STEP_DEF    = 4;
    localparam int          FIFO_DEPTH_DEF = 4;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue; storage is left unreset, only pointers and count are cleared.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int W     = INST_W_DEF + ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            dout,
    output logic [cnt_w(DEPTH)-1:0] count
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= FULL);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && count == FULL));
endmodule

// File: rtl/fetch_unit.sv
// PC generation, one-cycle imem request tracking, credit-based issue and redirect flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                INST_W     = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter int                PC_STEP    = PC_STEP_DEF,
    parameter int                FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [INST_W-1:0]            imem_rdata,
    input  logic                         redirect_en,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INST_W-1:0]            out_inst,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [cnt_w(FIFO_DEPTH)-1:0] fifo_count
);
    localparam int CNT_W = cnt_w(FIFO_DEPTH);

    logic [ADDR_W-1:0]        pc_p0;
    logic                     vld_p1;
    logic [ADDR_W-1:0]        inflight_pc_p1;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           occupancy;
    logic                     has_credit;
    logic                     push;
    logic                     pop;
    logic [INST_W+ADDR_W-1:0] head;

    assign out_valid = rst_n & ~redirect_en & (count != '0);
    assign pop       = out_valid & out_ready;

    // Queued plus in-flight entries bound the space a new request may claim.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1} - {{CNT_W{1'b0}}, pop};
    assign has_credit = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req   = rst_n & ~redirect_en & has_credit;
    assign imem_addr  = pc_p0;

    // p0 -> p1: request issued, data returns next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
        end else if (redirect_en) begin
            pc_p0  <= redirect_pc;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= imem_req;
            if (imem_req) pc_p0 <= pc_p0 + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req) inflight_pc_p1 <= pc_p0;
    end

    // p1 -> queue: response captured unless a redirect is killing it
    assign push = rst_n & vld_p1 & ~redirect_en;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INST_W + ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_en),
        .din   ({imem_rdata, inflight_pc_p1}),
        .dout  (head),
        .count (count)
    );

    assign out_inst   = head[ADDR_W +: INST_W];
    assign out_pc     = head[ADDR_W-1:0];
    assign fifo_count = rst_n ? count : '0;
endmodule
